// File: rtl/mac_sequencer_pkg.sv
// Shared types and helpers for the mac_sequencer block (optional overflow flag: MAC_SEQUENCER_OVF_EN).
package mac_seq_pkg;

    localparam int SZ_DEF    = 8;
    localparam int LEN_W_DEF = 4;
    localparam int MAX_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Low MAX_W bits of the product; callers narrow further to their own width.
    function automatic logic [MAX_W-1:0] trunc_prod(input logic [MAX_W-1:0] a,
                                                    input logic [MAX_W-1:0] b);
        return a * b;
    endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Job control, operand stream and result handshake of mac_sequencer (ovf present with MAC_SEQUENCER_OVF_EN).
interface mac_sequencer_if
    import mac_seq_pkg::*;
#(
    parameter int SZ    = SZ_DEF,
    parameter int LEN_W = LEN_W_DEF
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic [SZ-1:0]    z_init;
    logic             abort;
    logic             busy;
    logic             op_req;
    logic             op_vld;
    logic [SZ-1:0]    x_in;
    logic [SZ-1:0]    y_in;
    logic             res_vld;
    logic [SZ-1:0]    res;
    logic             res_ack;
`ifdef MAC_SEQUENCER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, len, z_init, abort, op_vld, x_in, y_in, res_ack,
`ifdef MAC_SEQUENCER_OVF_EN
        input  ovf,
`endif
        input  busy, op_req, res_vld, res
    );

    modport slave (
        input  start, len, z_init, abort, op_vld, x_in, y_in, res_ack,
`ifdef MAC_SEQUENCER_OVF_EN
        output ovf,
`endif
        output busy, op_req, res_vld, res
    );

endinterface

// File: rtl/mac_sequencer_step.sv
// mac_step: accumulator register with load and enable; next sum = acc + truncated x*y (wraps).
// With MAC_SEQUENCER_OVF_EN it also flags a nonzero product high half or an adder carry.
module mac_step
    import mac_seq_pkg::*;
#(
    parameter int SZ = SZ_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [SZ-1:0] i_z_init,
    input  logic          i_en,
    input  logic [SZ-1:0] i_x,
    input  logic [SZ-1:0] i_y,
`ifdef MAC_SEQUENCER_OVF_EN
    output logic          o_ovf_ev,
`endif
    output logic [SZ-1:0] o_acc,
    output logic [SZ-1:0] o_sum
);
    logic [SZ-1:0] r_acc;
    logic [SZ-1:0] w_prod;

    assign w_prod = SZ'(trunc_prod(MAX_W'(i_x), MAX_W'(i_y)));

`ifdef MAC_SEQUENCER_OVF_EN
    logic [SZ:0]     w_sum_x;
    logic [2*SZ-1:0] w_full;
    assign w_full   = {{SZ{1'b0}}, i_x} * {{SZ{1'b0}}, i_y};
    assign w_sum_x  = {1'b0, r_acc} + {1'b0, w_prod};
    assign o_sum    = w_sum_x[SZ-1:0];
    assign o_ovf_ev = (|w_full[2*SZ-1:SZ]) | w_sum_x[SZ];
`else
    assign o_sum    = r_acc + w_prod;
`endif

    assign o_acc = r_acc;

    // Accumulator: load wins over enable; otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= {SZ{1'b0}};
        end else if (i_load) begin
            r_acc <= i_z_init;
        end else if (i_en) begin
            r_acc <= o_sum;
        end else begin
            r_acc <= r_acc;
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer: runs one multiply-accumulate job over len operand pairs and hands back the result.
// Optional sticky overflow output enabled by MAC_SEQUENCER_OVF_EN.
module mac_sequencer
    import mac_seq_pkg::*;
#(
    parameter int SZ    = SZ_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    mac_sequencer_if.slave io_bus
);
    state_t           r_state;
    logic [LEN_W-1:0] r_cnt;
    logic [SZ-1:0]    r_res;
    logic [SZ-1:0]    w_acc;
    logic [SZ-1:0]    w_sum;
    logic             w_load;
    logic             w_accept;
`ifdef MAC_SEQUENCER_OVF_EN
    logic             w_ovf_ev;
    logic             r_ovf;
    assign io_bus.ovf = r_ovf;
`endif

    // Abort outranks both job start and operand acceptance.
    assign w_load   = (r_state == ST_IDLE)  && io_bus.start  && !io_bus.abort;
    assign w_accept = (r_state == ST_ACCUM) && io_bus.op_vld && !io_bus.abort;

    mac_step #(.SZ(SZ)) u_step (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_z_init (io_bus.z_init),
        .i_en     (w_accept),
        .i_x      (io_bus.x_in),
        .i_y      (io_bus.y_in),
`ifdef MAC_SEQUENCER_OVF_EN
        .o_ovf_ev (w_ovf_ev),
`endif
        .o_acc    (w_acc),
        .o_sum    (w_sum)
    );

    assign io_bus.busy    = (r_state != ST_IDLE);
    assign io_bus.op_req  = (r_state == ST_ACCUM);
    assign io_bus.res_vld = (r_state == ST_DONE);
    assign io_bus.res     = r_res;

    // Job FSM with remaining-pair counter and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= {LEN_W{1'b0}};
            r_res   <= {SZ{1'b0}};
`ifdef MAC_SEQUENCER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_cnt <= io_bus.len;
`ifdef MAC_SEQUENCER_OVF_EN
                        r_ovf <= 1'b0;
`endif
                        if (io_bus.len == {LEN_W{1'b0}}) begin
                            r_state <= ST_DONE;
                            r_res   <= io_bus.z_init;
                        end else begin
                            r_state <= ST_ACCUM;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACCUM: begin
                    if (io_bus.abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_accept) begin
                        r_cnt <= r_cnt - {{(LEN_W-1){1'b0}}, 1'b1};
`ifdef MAC_SEQUENCER_OVF_EN
                        r_ovf <= r_ovf | w_ovf_ev;
`endif
                        if (r_cnt == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                            r_state <= ST_DONE;
                            r_res   <= w_sum;
                        end else begin
                            r_state <= ST_ACCUM;
                        end
                    end else begin
                        r_state <= ST_ACCUM;
                    end
                end
                ST_DONE: begin
                    // acc is frozen here, so this keeps res equal to it.
                    r_res <= w_acc;
                    if (io_bus.abort || io_bus.res_ack) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: spec-level model compared every cycle plus directed literal checks.
module tb_mac_sequencer;
    import mac_seq_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mac_sequencer_if #(.SZ(8), .LEN_W(4)) bus ();
    mac_sequencer #(.SZ(8), .LEN_W(4)) dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));

    int n_chk = 0;
    int n_fail = 0;
    int busy_cnt = 0;
    int req_cnt = 0;

    // Model state: phase 0 = no job, 1 = collecting pairs, 2 = result offered.
    int         m_phase = 0;
    int         m_left = 0;
    int         m_acc = 0;
    logic [7:0] m_res = 8'h00;
    logic       m_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        int p;
        int s;
        if (!rst_n) begin
            m_phase = 0; m_left = 0; m_acc = 0; m_res = 8'h00; m_ovf = 1'b0;
        end else if (m_phase == 0) begin
            if (bus.start && !bus.abort) begin
                m_acc = int'(bus.z_init);
                m_ovf = 1'b0;
                if (bus.len == 4'd0) begin
                    m_phase = 2;
                    m_res   = bus.z_init;
                end else begin
                    m_left  = int'(bus.len);
                    m_phase = 1;
                end
            end
        end else if (m_phase == 1) begin
            if (bus.abort) begin
                m_phase = 0;
            end else if (bus.op_vld) begin
                p = int'(bus.x_in) * int'(bus.y_in);
                if (p > 255) m_ovf = 1'b1;
                s = m_acc + (p % 256);
                if (s > 255) m_ovf = 1'b1;
                m_acc = s % 256;
                m_left--;
                if (m_left == 0) begin
                    m_phase = 2;
                    m_res   = 8'(m_acc);
                end
            end
        end else begin
            if (bus.abort || bus.res_ack) m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 32'(bus.busy), 32'(m_phase != 0));
            chk("op_req", 32'(bus.op_req), 32'(m_phase == 1));
            chk("res_vld", 32'(bus.res_vld), 32'(m_phase == 2));
            chk("res", 32'(bus.res), 32'(m_res));
`ifdef MAC_SEQUENCER_OVF_EN
            if (m_phase == 2) chk("ovf", 32'(bus.ovf), 32'(m_ovf));
`endif
            if (bus.busy) busy_cnt++;
            if (bus.op_req) req_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic job_start(input logic [3:0] l, input logic [7:0] z);
        bus.start = 1'b1; bus.len = l; bus.z_init = z;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pair(input logic [7:0] x, input logic [7:0] y);
        bus.op_vld = 1'b1; bus.x_in = x; bus.y_in = y;
        tick();
        bus.op_vld = 1'b0;
    endtask

    task automatic ack();
        bus.res_ack = 1'b1;
        tick();
        bus.res_ack = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.len = 4'd0; bus.z_init = 8'h00; bus.abort = 1'b0;
        bus.op_vld = 1'b0; bus.x_in = 8'h00; bus.y_in = 8'h00; bus.res_ack = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_op_req", 32'(bus.op_req), 32'd0);
        chk("rst_res_vld", 32'(bus.res_vld), 32'd0);
        chk("rst_res", 32'(bus.res), 32'd0);
        #9 rst_n = 1'b1;
        tick();

        // Basic job: 3 + 10 + 16 + 7 = 0x24
        busy_cnt = 0;
        job_start(4'd3, 8'h03);
        bus.op_vld = 1'b1; bus.x_in = 8'd2; bus.y_in = 8'd5; tick();
        bus.x_in = 8'd4; bus.y_in = 8'd4; tick();
        bus.x_in = 8'd1; bus.y_in = 8'd7; tick();
        bus.op_vld = 1'b0;
        chk("basic_res_vld", 32'(bus.res_vld), 32'd1);
        chk("basic_res", 32'(bus.res), 32'h24);
        chk("model_basic_res", 32'(m_res), 32'h24);
        ack();
        chk("basic_busy_cycles", 32'(busy_cnt), 32'd4);
        chk("basic_idle_after_ack", 32'(bus.busy), 32'd0);

        // Truncation: 0x20*0x10 = 0x200 keeps only 0x00
        job_start(4'd1, 8'h00);
        pair(8'h20, 8'h10);
        chk("trunc_res_vld", 32'(bus.res_vld), 32'd1);
        chk("trunc_res", 32'(bus.res), 32'h00);
`ifdef MAC_SEQUENCER_OVF_EN
        chk("trunc_ovf", 32'(bus.ovf), 32'd1);
`endif
        ack();

        // Wrap: 0xF0 + 0x20 = 0x110 -> 0x10, then + 1 = 0x11
        job_start(4'd2, 8'hF0);
        pair(8'h10, 8'h02);
        tick();
        chk("wrap_gap_acc1", 32'(dut.u_step.r_acc), 32'h10);
        chk("wrap_gap_req", 32'(bus.op_req), 32'd1);
        tick();
        chk("wrap_gap_acc2", 32'(dut.u_step.r_acc), 32'h10);
        chk("wrap_gap_vld", 32'(bus.res_vld), 32'd0);
        pair(8'h01, 8'h01);
        chk("wrap_res", 32'(bus.res), 32'h11);
        chk("model_wrap_res", 32'(m_res), 32'h11);
`ifdef MAC_SEQUENCER_OVF_EN
        chk("wrap_ovf", 32'(bus.ovf), 32'd1);
`endif
        ack();

        // Zero-length job; start while in DONE is ignored
        req_cnt = 0;
        job_start(4'd0, 8'h5A);
        chk("zero_res_vld", 32'(bus.res_vld), 32'd1);
        chk("zero_res", 32'(bus.res), 32'h5A);
        chk("zero_op_req", 32'(bus.op_req), 32'd0);
        bus.start = 1'b1; bus.len = 4'd2; bus.z_init = 8'h11;
        tick();
        bus.start = 1'b0;
        chk("zero_start_ignored", 32'(bus.res_vld), 32'd1);
        chk("zero_res_kept", 32'(bus.res), 32'h5A);
        ack();
        chk("zero_idle", 32'(bus.busy), 32'd0);
        chk("zero_never_req", 32'(req_cnt), 32'd0);

        // Abort after two accepts: acc 7+1+4 = 12 stays, res untouched
        job_start(4'd4, 8'h07);
        pair(8'd1, 8'd1);
        pair(8'd2, 8'd2);
        bus.abort = 1'b1; bus.op_vld = 1'b1; bus.x_in = 8'd3; bus.y_in = 8'd3;
        tick();
        bus.abort = 1'b0; bus.op_vld = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_res_vld", 32'(bus.res_vld), 32'd0);
        chk("abort_res", 32'(bus.res), 32'h5A);
        chk("abort_acc", 32'(dut.u_step.r_acc), 32'h0C);
        // Abort in IDLE masks start
        bus.abort = 1'b1; bus.start = 1'b1; bus.len = 4'd1;
        tick();
        bus.abort = 1'b0; bus.start = 1'b0;
        chk("abort_idle_start", 32'(bus.busy), 32'd0);

        // New job after abort: 1 + 9 = 0x0A
        job_start(4'd1, 8'h01);
        pair(8'd3, 8'd3);
        chk("after_abort_res", 32'(bus.res), 32'h0A);
        chk("after_abort_vld", 32'(bus.res_vld), 32'd1);
        ack();

        // Asynchronous reset mid-ACCUM
        job_start(4'd3, 8'h09);
        pair(8'd2, 8'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_op_req", 32'(bus.op_req), 32'd0);
        chk("arst_res_vld", 32'(bus.res_vld), 32'd0);
        chk("arst_res", 32'(bus.res), 32'd0);
        #3 rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_idle", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
